dmem: RTL

Data memory responder for the load/store path of the single-issue RISC-V core. It answers the decode stage's read request (`mem_ren`, `mem_raddr`) with one registered 32-bit word. It accepts byte-strobed writes from the execute stage. It sits beside the register file as the far end of the decoder's memory-read interface.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data memory responder.
// Carries the bus widths and defaults the core's legacy defines used to supply.
// No logic; imported by dmem and dmem_ram.
package dmem_pkg;

    localparam int          REG_W      = 32;             // RegBus width
    localparam int          MEM_STRB_W = 4;              // MemStrbBus width
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        ENABLE     = 1'b1;
    localparam logic        DISABLE    = 1'b0;
    localparam int          DMEM_DEPTH = 4096;           // default word count
    localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;  // default base byte address

    // Replace the byte lanes of old_w selected by strb with those of new_w.
    function automatic logic [REG_W-1:0] byte_merge(
        input logic [REG_W-1:0]      old_w,
        input logic [REG_W-1:0]      new_w,
        input logic [MEM_STRB_W-1:0] strb
    );
        logic [REG_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MEM_STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage: one byte-enabled write port, one synchronous read port.
// Latency: read data registered one edge after rd_en; read-before-write on a shared index.
// No backpressure, no reset; ports: clk, wr_en/idx/dat/strb, rd_en/idx, rd_dat.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_idx,
    input  logic [REG_W-1:0]      wr_dat,
    input  logic [MEM_STRB_W-1:0] wr_strb,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_idx,
    output logic [REG_W-1:0]      rd_dat
);

    logic [REG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MEM_STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
        // Returns the pre-write word; dmem patches in same-edge write lanes.
        if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/dmem.sv
// Data memory responder: range-checked byte-strobed writes, one-word reads.
// Latency: read data/valid/err one cycle after request; writes visible to the next read.
// No backpressure: every read is answered; out-of-range accesses flag rerr/werr.
// Ports: clk, rst_n, mem_ren/raddr, mem_wen/waddr/wdata/wstrb, mem_rdata/rvalid/rerr, mem_werr.
module dmem
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ren,
    input  logic [REG_W-1:0]      mem_raddr,
    input  logic                  mem_wen,
    input  logic [REG_W-1:0]      mem_waddr,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic [MEM_STRB_W-1:0] mem_wstrb,
    output logic [REG_W-1:0]      mem_rdata,
    output logic                  mem_rvalid,
    output logic                  mem_rerr,
    output logic                  mem_werr
);

    localparam int AW = $clog2(DEPTH);

    // Bounds kept in 33 bits so BASE_ADDR + 4*DEPTH past 2^32 does not wrap.
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    logic [32:0] r_off, w_off;
    logic        r_in, w_in;
    logic [AW-1:0] r_idx, w_idx;

    assign r_off = {1'b0, mem_raddr} - ADDR_LO;
    assign w_off = {1'b0, mem_waddr} - ADDR_LO;
    assign r_in  = ({1'b0, mem_raddr} >= ADDR_LO) && ({1'b0, mem_raddr} < ADDR_HI);
    assign w_in  = ({1'b0, mem_waddr} >= ADDR_LO) && ({1'b0, mem_waddr} < ADDR_HI);
    assign r_idx = r_off[AW+1:2];
    assign w_idx = w_off[AW+1:2];

    // Byte-offset bits and bits above the index only matter through the range check.
    logic unused_off_bits;
    assign unused_off_bits = ^{r_off[32:AW+2], r_off[1:0], w_off[32:AW+2], w_off[1:0]};

    // run_q is low on the edge that releases reset, so a write sampled there is dropped.
    logic run_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    logic wr_go, rd_go, collide;
    assign wr_go   = mem_wen && w_in && run_q;
    assign rd_go   = mem_ren && r_in;
    assign collide = wr_go && rd_go && (w_idx == r_idx);

    logic [REG_W-1:0] ram_q;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_go),
        .wr_idx  (w_idx),
        .wr_dat  (mem_wdata),
        .wr_strb (mem_wstrb),
        .rd_en   (rd_go),
        .rd_idx  (r_idx),
        .rd_dat  (ram_q)
    );

    // Output state. The RAM read register has no reset, so zero_q forces the
    // visible word to ZERO_WORD after reset and after an out-of-range read; it,
    // and the forwarded lanes, only change on read edges so mem_rdata holds.
    logic                  rvalid_q, rerr_q, werr_q, zero_q;
    logic [MEM_STRB_W-1:0] fwd_strb_q;
    logic [REG_W-1:0]      fwd_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= DISABLE;
            rerr_q     <= DISABLE;
            werr_q     <= DISABLE;
            zero_q     <= 1'b1;
            fwd_strb_q <= '0;
            fwd_dat_q  <= ZERO_WORD;
        end else begin
            rvalid_q <= (mem_ren == ENABLE);
            rerr_q   <= mem_ren && !r_in;
            werr_q   <= mem_wen && !w_in && run_q;
            if (mem_ren) begin
                zero_q     <= !r_in;
                fwd_strb_q <= collide ? mem_wstrb : '0;
                fwd_dat_q  <= mem_wdata;
            end
        end
    end

    assign mem_rdata  = zero_q ? ZERO_WORD : byte_merge(ram_q, fwd_dat_q, fwd_strb_q);
    assign mem_rvalid = rvalid_q;
    assign mem_rerr   = rerr_q;
    assign mem_werr   = werr_q;

endmodule
